// File: rtl/cordic_ci_pkg.sv
// rtl/cordic_ci_pkg.sv - shared constants and state encoding for the CI issue master
// Purpose : FSM state type, default operand width, abort value and counter width
//           used by cordic_ci_master.
package cordic_ci_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam int          TXN_W        = 16;
  localparam logic [31:0] QNAN_VALUE   = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/cordic_ci_master.sv
// rtl/cordic_ci_master.sv - multicycle custom-instruction initiator fed from a valid/ready stream
// Purpose : takes one float operand at a time from the input stream, issues it to a
//           start/done CI slave, and returns the slave result on the response stream.
// Config  : CI_TIMEOUT_EN - when defined, WAIT is bounded by TIMEOUT_CYCLES and an
//           expired wait returns ERR_VALUE with out_err=1 and pulses ci_aclr.
// Ports   : clock, aclr_n          - clock, asynchronous active-low reset
//           en                     - global enable, freezes the whole block when 0
//           in_valid/in_ready/in_data     - operand stream
//           ci_clk_en/ci_aclr/ci_start/ci_dataa/ci_done/ci_result - slave interface
//           out_valid/out_ready/out_data/out_err - response stream
//           txn_count              - completed responses, wrapping
module cordic_ci_master
  import cordic_ci_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef CI_TIMEOUT_EN
  , parameter int                TIMEOUT_CYCLES = 64
  , parameter logic [DATA_W-1:0] ERR_VALUE      = DATA_W'(QNAN_VALUE)
`endif
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ci_clk_en,
  output logic              ci_aclr,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  input  logic              ci_done,
  input  logic [DATA_W-1:0] ci_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [TXN_W-1:0]  txn_count
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  dataa_q, dataa_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               err_q, err_d;
  logic               aclr_q, aclr_d;
  logic [TXN_W-1:0]   txn_q, txn_d;

`ifdef CI_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    dataa_d   = dataa_q;
    res_d     = res_q;
    err_d     = err_q;
    aclr_d    = 1'b0;
    txn_d     = txn_q;
    in_ready  = 1'b0;
    ci_start  = 1'b0;
    out_valid = 1'b0;
`ifdef CI_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          // Hold off while the slave is still being cleared.
          in_ready = ~aclr_q;
          if (in_valid && !aclr_q) begin
            dataa_d = in_data;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ci_start = 1'b1;
          state_d  = ST_WAIT;
`ifdef CI_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
        ST_WAIT: begin
          // done takes priority over an expiring timeout in the same cycle.
          if (ci_done) begin
            res_d   = ci_result;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end
`ifdef CI_TIMEOUT_EN
          else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            res_d   = ERR_VALUE;
            err_d   = 1'b1;
            aclr_d  = 1'b1;
            state_d = ST_RESP;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          out_valid = 1'b1;
          if (out_ready) begin
            txn_d   = txn_q + 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= ST_IDLE;
      dataa_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      aclr_q  <= 1'b1;  // keeps the slave cleared for one cycle past release
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      dataa_q <= dataa_d;
      res_q   <= res_d;
      err_q   <= err_d;
      aclr_q  <= aclr_d;
      txn_q   <= txn_d;
    end
  end

`ifdef CI_TIMEOUT_EN
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end
  assign out_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign out_err    = 1'b0;
`endif

  assign ci_clk_en = en;
  assign ci_aclr   = aclr_q;
  assign ci_dataa  = dataa_q;
  assign out_data  = res_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_cordic_ci_master.sv
// tb/tb_cordic_ci_master.sv - directed self-checking bench for cordic_ci_master with a stub slave
module tb_cordic_ci_master;

  logic        clock = 1'b0;
  logic        aclr_n, en, in_valid, in_ready, ci_clk_en, ci_aclr, ci_start;
  logic        ci_done, out_valid, out_ready, out_err;
  logic [31:0] in_data, ci_dataa, ci_result, out_data;
  logic [15:0] txn_count;

  cordic_ci_master dut (
    .clock(clock), .aclr_n(aclr_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ci_clk_en(ci_clk_en), .ci_aclr(ci_aclr), .ci_start(ci_start), .ci_dataa(ci_dataa),
    .ci_done(ci_done), .ci_result(ci_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .txn_count(txn_count)
  );

  always #5 clock = ~clock;

  // Stub slave: result = ~dataa, done pulses stub_lat cycles after the start pulse.
  int   stub_lat = 5;
  int   stub_cnt = 0;
  logic stub_mute = 1'b0;
  logic extra_done = 1'b0;

  always @(posedge clock or posedge ci_aclr) begin
    if (ci_aclr) stub_cnt <= 0;
    else if (ci_clk_en) begin
      if (ci_start && !stub_mute) stub_cnt <= stub_lat;
      else if (stub_cnt > 0)      stub_cnt <= stub_cnt - 1;
    end
  end
  assign ci_done   = (stub_cnt == 1) || extra_done;
  assign ci_result = ~ci_dataa;

  // Monitors
  int cyc = 0, start_cnt = 0, aclr_pulses = 0, overlap = 0;
  bit outst = 0;
  always @(posedge clock) begin
    cyc++;
    if (!aclr_n) outst = 0;
    else begin
      if (out_valid && out_ready) outst = 0;
      if (ci_start) begin
        if (outst) overlap++;
        outst = 1;
        start_cnt++;
      end
      if (ci_aclr) aclr_pulses++;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] d, output int acc_cyc);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin ok = 1; break; end
      tick;
    end
    check("accept_bound", 32'(ok), 32'd1);
    acc_cyc = cyc;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic await_resp(output int r_cyc);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin ok = 1; break; end
      tick;
    end
    check("resp_bound", 32'(ok), 32'd1);
    r_cyc = cyc;
  endtask

  logic [31:0] vec [11] = '{32'h00000000, 32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A,
                            32'h3ECCCCCD, 32'h3F000000, 32'h3F19999A, 32'h3F333333,
                            32'h3F4CCCCD, 32'h3F666666, 32'h3F800000};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, r, s0, p0;
    bit stable, ir_seen, st_seen;
    logic [31:0] d0;

    aclr_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick; tick;
    // Reset values
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_ci_start",  32'(ci_start),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_ci_dataa",  ci_dataa,       32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_txn",       32'(txn_count), 32'd0);
    check("rst_ci_aclr",   32'(ci_aclr),   32'd1);
    aclr_n = 1'b1;
    #1;
    check("rel_ci_aclr_hi", 32'(ci_aclr),  32'd1);
    check("rel_in_ready",   32'(in_ready), 32'd0);
    tick;
    check("rel_ci_aclr_lo", 32'(ci_aclr),  32'd0);
    check("idle_in_ready",  32'(in_ready), 32'd1);

    // 1: single operand, L=5
    stub_lat = 5; s0 = start_cnt;
    issue(32'h3F000000, a);
    await_resp(r);
    check("t1_latency", 32'(r - a), 32'd7);
    check("t1_data",    out_data,   32'hC0FFFFFF);
    check("t1_err",     32'(out_err), 32'd0);
    tick;
    check("t1_txn",     32'(txn_count), 32'd1);
    check("t1_starts",  32'(start_cnt - s0), 32'd1);

    // 2: 11 back-to-back operands, L=16
    stub_lat = 16;
    for (int i = 0; i < 11; i++) begin
      issue(vec[i], a);
      await_resp(r);
      check($sformatf("t2_data_%0d", i), out_data, ~vec[i]);
      check($sformatf("t2_lat_%0d", i), 32'(r - a), 32'd18);
    end
    tick;
    check("t2_txn",     32'(txn_count), 32'd12);
    check("t2_overlap", 32'(overlap),   32'd0);

    // 3: back-pressure in RESP for 20 cycles
    stub_lat = 3; out_ready = 1'b0;
    issue(32'h12345678, a);
    await_resp(r);
    d0 = out_data; s0 = start_cnt;
    stable = 1; ir_seen = 0;
    in_valid = 1'b1; in_data = 32'h0BADF00D;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid || out_data !== d0) stable = 0;
      if (in_ready) ir_seen = 1;
      tick;
    end
    in_valid = 1'b0;
    check("t3_data",      d0,              32'hEDCBA987);
    check("t3_stable",    32'(stable),     32'd1);
    check("t3_in_ready",  32'(ir_seen),    32'd0);
    check("t3_no_start",  32'(start_cnt - s0), 32'd0);
    out_ready = 1'b1;
    tick;
    check("t3_txn",       32'(txn_count),  32'd13);
    check("t3_ready_next", 32'(in_ready),  32'd1);

`ifdef CI_TIMEOUT_EN
    // 4: slave never answers
    stub_mute = 1'b1; out_ready = 1'b0; p0 = aclr_pulses;
    issue(32'h3F000000, a);
    await_resp(r);
    check("t4_latency", 32'(r - a), 32'd66);
    check("t4_err",     32'(out_err), 32'd1);
    check("t4_data",    out_data,     32'h7FC00000);
    check("t4_aclr_hi", 32'(ci_aclr), 32'd1);
    tick;
    check("t4_aclr_lo", 32'(ci_aclr), 32'd0);
    check("t4_pulses",  32'(aclr_pulses - p0), 32'd1);
    stub_mute = 1'b0; out_ready = 1'b1;
    tick;
    check("t4_txn",     32'(txn_count), 32'd14);
`endif

    // 5: reset during WAIT
    stub_lat = 10;
    issue(32'h3F000000, a);
    tick; tick; tick;
    aclr_n = 1'b0;
    #1;
    check("t5_in_ready",  32'(in_ready),  32'd0);
    check("t5_ci_start",  32'(ci_start),  32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_ci_dataa",  ci_dataa,       32'd0);
    check("t5_out_data",  out_data,       32'd0);
    check("t5_txn",       32'(txn_count), 32'd0);
    check("t5_ci_aclr",   32'(ci_aclr),   32'd1);
    tick; tick; tick;
    aclr_n = 1'b1;
    extra_done = 1'b1;
    #1;
    check("t5_rel_aclr_hi", 32'(ci_aclr), 32'd1);
    tick;
    extra_done = 1'b0;
    check("t5_rel_aclr_lo", 32'(ci_aclr),   32'd0);
    check("t5_late_done_valid", 32'(out_valid), 32'd0);
    check("t5_late_done_idle",  32'(in_ready),  32'd1);
    check("t5_late_done_data",  out_data,       32'd0);

    // 6: en low for 10 cycles while in ISSUE
    stub_lat = 4; s0 = start_cnt;
    issue(32'h40490FDB, a);
    en = 1'b0;
    #1;
    st_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (ci_start || ci_clk_en) st_seen = 1;
      tick;
    end
    check("t6_frozen", 32'(st_seen), 32'd0);
    en = 1'b1;
    #1;
    check("t6_start_back", 32'(ci_start), 32'd1);
    await_resp(r);
    check("t6_data",   out_data, 32'hBFB6F024);
    check("t6_starts", 32'(start_cnt - s0), 32'd1);
    tick;
    check("t6_txn",    32'(txn_count), 32'd1);
    check("final_overlap", 32'(overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
